majority_logic_decoder_stream: RTL and testbench



---
 rtl/majority_logic_decoder_stream.sv | 142 ++++++++++++++
 tb/tb_majority_logic_decoder_stream.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/majority_logic_decoder_stream.sv
// majority_logic_decoder_stream
//
// One-step majority-logic decoder for cyclic block codes. A received word is
// loaded serially (position 0 first), then corrected in place over N decode
// cycles: each cycle the J orthogonal check sums on position N-1 are formed,
// position N-1 is flipped when at least THRESH of them are 1, and the buffer
// is rotated one place toward higher positions. After N rotations the buffer
// is back in its original order and is presented on the output handshake.
// Defaults decode the (15,7) double-error-correcting BCH code.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready and out_valid are registered and never depend
// combinationally on in_valid or out_ready. While out_valid is 1 and
// out_ready is 0, decoded_vector and err_count hold stable.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; returns to LOAD, discards data
//   in_valid       in_bit is valid
//   in_ready       block accepts a bit this cycle (LOAD only)
//   in_bit         received bit, position 0 first, position N-1 last
//   out_valid      decoded_vector / err_count are valid (DONE)
//   out_ready      consumer accepts the result
//   decoded_vector corrected word, bit i = coefficient of x^i
//   err_count      number of bits flipped while decoding (saturates at N)
//   state_dbg      current FSM state (0 LOAD, 1 DECODE, 2 DONE)
module majority_logic_decoder_stream #(
    parameter int N      = 15,
    parameter int J      = 4,
    parameter int THRESH = 3,
    parameter logic [J*N-1:0] CS_MASK = {15'h4580, 15'h5808, 15'h6022, 15'h4045}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_bit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             decoded_vector,
    output logic [$clog2(N+1)-1:0]   err_count,
    output logic [1:0]               state_dbg
);

    localparam int EW    = $clog2(N+1);
    localparam int CNT_W = $clog2(N);
    localparam int SW    = $clog2(J+1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);
    localparam logic [EW-1:0]    ERR_MAX  = EW'(N);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     shift_q;
    logic [CNT_W-1:0] cnt_q;

    logic [J-1:0]     chk_vec;
    logic [SW-1:0]    syn_cnt;
    logic             flip;
    logic [N-1:0]     shift_next;

    assign state_dbg = state_q;

    // Check sums on the current buffer. Position N-1 always participates, so
    // after k rotations they vote on original position N-1-k. Bits already
    // corrected in earlier steps feed into these sums.
    always_comb begin
        chk_vec = '0;
        syn_cnt = '0;
        for (int j = 0; j < J; j++) begin
            chk_vec[j] = ^(shift_q & CS_MASK[j*N +: N]);
            syn_cnt    = syn_cnt + SW'(chk_vec[j]);
        end
        flip       = (int'(syn_cnt) >= THRESH);
        shift_next = {shift_q[N-2:0], shift_q[N-1] ^ flip};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= LOAD;
            shift_q        <= '0;
            cnt_q          <= '0;
            err_count      <= '0;
            decoded_vector <= '0;
            out_valid      <= 1'b0;
            in_ready       <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_valid && in_ready) begin
                        shift_q[cnt_q] <= in_bit;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q    <= '0;
                            in_ready <= 1'b0;
                            state_q  <= DECODE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end

                DECODE: begin
                    shift_q <= shift_next;
                    if (flip && (err_count != ERR_MAX)) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        // Last rotation restores the original bit order.
                        cnt_q          <= '0;
                        decoded_vector <= shift_next;
                        out_valid      <= 1'b1;
                        state_q        <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        err_count <= '0;
                        state_q   <= LOAD;
                    end
                end

                default: begin
                    state_q   <= LOAD;
                    cnt_q     <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_majority_logic_decoder_stream.sv
module tb_majority_logic_decoder_stream;

    localparam int N  = 15;
    localparam int EW = $clog2(N+1);
    localparam int W  = N + EW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_bit = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  decoded_vector;
    logic [EW-1:0] err_count;
    logic [1:0]    state_dbg;

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard entries: {expected err_count, expected decoded word}
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [N-1:0] rx;
        logic [N-1:0] exp_word;
        int           exp_err;
        bit           bubbles;
        int           hold;
    } vec_t;

    vec_t vecs[5];

    majority_logic_decoder_stream dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_bit         (in_bit),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .decoded_vector (decoded_vector),
        .err_count      (err_count),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- drivers ----------------
    // Streams one word, position 0 first. Returns at #1 after the edge that
    // accepted the last bit.
    task automatic send_word(input logic [N-1:0] w, input bit bubbles);
        int  i = 0;
        int  guard = 0;
        bit  accepted;
        while (i < N && guard < 20*N) begin
            in_valid = (bubbles && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            in_bit   = w[i];
            accepted = in_valid && in_ready;
            @(posedge clk); #1;
            if (accepted) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        if (i < N) check("send_timeout", 32'(i), 32'(N));
    endtask

    // Waits for a result, holds out_ready low for `hold` cycles (with in_valid
    // asserted to show it is ignored), then completes the transfer.
    task automatic get_result(input int hold);
        int           lat = 0;
        logic [W-1:0] e;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("result_timeout", 32'(out_valid), 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(N));
        if (exp_q.size() == 0) begin
            check("unexpected_result", 32'(exp_q.size()), 32'd1);
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_bit   = 1'($urandom_range(0, 1));
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_decoded", 32'(decoded_vector), 32'(e[N-1:0]));
            check("hold_err_count", 32'(err_count), 32'(e[W-1:N]));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
        check("decoded_vector", 32'(decoded_vector), 32'(e[N-1:0]));
        check("err_count", 32'(err_count), 32'(e[W-1:N]));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("post_xfer_out_valid", 32'(out_valid), 32'd0);
        check("post_xfer_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic push_exp(input logic [N-1:0] word, input int err);
        exp_q.push_back({EW'(err), word});
    endtask

    // ---------------- test ----------------
    initial begin
        logic [N-1:0] pat;
        logic [N-1:0] bases[2];

        vecs[0] = '{rx: 15'h0000, exp_word: 15'h0000, exp_err: 0, bubbles: 1'b0, hold: 0};
        vecs[1] = '{rx: 15'h7DF7, exp_word: 15'h7FFF, exp_err: 2, bubbles: 1'b0, hold: 0};
        vecs[2] = '{rx: 15'h41D1, exp_word: 15'h01D1, exp_err: 1, bubbles: 1'b0, hold: 0};
        vecs[3] = '{rx: 15'h41D0, exp_word: 15'h01D1, exp_err: 2, bubbles: 1'b1, hold: 5};
        vecs[4] = '{rx: 15'h0080, exp_word: 15'h0000, exp_err: 1, bubbles: 1'b1, hold: 0};

        // Reset state
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_decoded", 32'(decoded_vector), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        for (int v = 0; v < 5; v++) begin
            push_exp(vecs[v].exp_word, vecs[v].exp_err);
            send_word(vecs[v].rx, vecs[v].bubbles);
            check("decode_state", 32'(state_dbg), 32'd1);
            check("decode_in_ready", 32'(in_ready), 32'd0);
            get_result(vecs[v].hold);
        end

        // Reset during decode step 6: aborted word must not reach the output
        send_word(15'h41D1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("pre_abort_state", 32'(state_dbg), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_state", 32'(state_dbg), 32'd0);
        check("abort_err_count", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        push_exp(15'h01D1, 0);
        send_word(15'h01D1, 1'b0);
        get_result(0);

        // All weight-1 and weight-2 error patterns on two codewords
        bases[0] = 15'h0000;
        bases[1] = 15'h01D1;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < N; i++) begin
                for (int j = i; j < N; j++) begin
                    pat = '0;
                    pat[i] = 1'b1;
                    pat[j] = 1'b1;
                    push_exp(bases[b], $countones(pat));
                    send_word(bases[b] ^ pat, (i + j) % 4 == 0);
                    get_result(0);
                end
            end
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
